// File: rtl/tri_bus_pkg.sv
// Shared types and width helpers for the tri-state bus controller.
// Optional 4-state sampling checks are enabled by defining TRI_BUS_XZ_CHECK_EN.
package tri_bus_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT  = 2'd1,
      SAMPLE = 2'd2,
      DEAD   = 2'd3
   } state_t;

   // Width of a driver index; a single-bit index is the floor.
   function automatic int id_width(input int n);
      if (n <= 1) begin
         return 1;
      end else begin
         return $clog2(n);
      end
   endfunction

   // Width of the shared settle/dead down-counter; it holds at most max-1.
   function automatic int cnt_width(input int settle, input int dead);
      int m;
      m = (settle > dead) ? settle : dead;
      if (m <= 2) begin
         return 1;
      end else begin
         return $clog2(m);
      end
   endfunction

endpackage

// File: rtl/tri_bus_rr_arb.sv
// Combinational round-robin priority select: picks the first requester at
// or above ptr, wrapping modulo N_DRV. Produces a one-hot grant and its index.
module tri_bus_rr_arb
   import tri_bus_pkg::*;
#(
   parameter int N_DRV = 3,
   parameter int IW    = id_width(N_DRV)
) (
   input  logic [N_DRV-1:0] req,
   input  logic [IW-1:0]    ptr,
   output logic [N_DRV-1:0] gnt,
   output logic [IW-1:0]    idx,
   output logic             any
);

   logic [2*N_DRV-1:0] dbl_s;
   logic [N_DRV-1:0]   rot_s;
   logic [IW-1:0]      off_s;
   logic [IW:0]        sum_s;

   // Rotate requests so the pointer position sits at bit 0, then find the
   // lowest set offset and map it back to an absolute driver index.
   always_comb begin
      dbl_s = {req, req} >> ptr;
      rot_s = dbl_s[N_DRV-1:0];
      off_s = {IW{1'b0}};
      any   = |req;
      for (int i = N_DRV - 1; i >= 0; i--) begin
         if (rot_s[i]) begin
            off_s = IW'(i);
         end else begin
            off_s = off_s;
         end
      end
      sum_s = {1'b0, ptr} + {1'b0, off_s};
      if (sum_s >= (IW+1)'(N_DRV)) begin
         sum_s = sum_s - (IW+1)'(N_DRV);
      end else begin
         sum_s = sum_s;
      end
      idx = sum_s[IW-1:0];
      gnt = {N_DRV{1'b0}};
      for (int j = 0; j < N_DRV; j++) begin
         gnt[j] = any && (idx == IW'(j));
      end
   end

endmodule

// File: rtl/tri_bus_ctrl.sv
// Round-robin grant controller and sampler for a shared tri-state net.
// Raises one driver enable, waits SETTLE_CYC cycles, samples the net, then
// holds all enables low for a break-before-make interval.
// Define TRI_BUS_XZ_CHECK_EN to flag floating (Z) or contended (X) samples.
module tri_bus_ctrl
   import tri_bus_pkg::*;
#(
   parameter int N_DRV      = 3,
   parameter int SETTLE_CYC = 2,
   parameter int DEAD_CYC   = 1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [N_DRV-1:0]            req,
   input  logic                        bus_in,
   input  logic                        clr_err,
   output logic [N_DRV-1:0]            en,
   output logic [id_width(N_DRV)-1:0]  grant_id,
   output logic                        data_out,
   output logic                        data_valid,
   output logic                        busy,
   output logic                        float_err,
   output logic                        contention_err
);

   localparam int IW = id_width(N_DRV);
   localparam int CW = cnt_width(SETTLE_CYC, DEAD_CYC);

   state_t            state_r, state_s;
   logic [CW-1:0]     cnt_r, cnt_s;
   logic [N_DRV-1:0]  en_r, en_s;
   logic [IW-1:0]     grant_id_r, grant_id_s;
   logic [IW-1:0]     ptr_r, ptr_s;
   logic              data_out_r, data_out_s;
   logic              data_valid_r, data_valid_s;
   logic              busy_r, busy_s;
   logic              float_r, float_s;
   logic              cont_r, cont_s;
   logic              float_set_s, cont_set_s;

   logic [N_DRV-1:0]  arb_gnt_s;
   logic [IW-1:0]     arb_idx_s;
   logic              arb_any_s;

   tri_bus_rr_arb #(
      .N_DRV (N_DRV),
      .IW    (IW)
   ) u_arb (
      .req (req),
      .ptr (ptr_r),
      .gnt (arb_gnt_s),
      .idx (arb_idx_s),
      .any (arb_any_s)
   );

   // Next-state and next-output logic for the grant/settle/sample/dead cycle.
   always_comb begin
      state_s      = state_r;
      cnt_s        = cnt_r;
      en_s         = en_r;
      grant_id_s   = grant_id_r;
      ptr_s        = ptr_r;
      data_out_s   = data_out_r;
      data_valid_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (arb_any_s) begin
               en_s       = arb_gnt_s;
               grant_id_s = arb_idx_s;
               cnt_s      = CW'(SETTLE_CYC - 1);
               state_s    = GRANT;
            end else begin
               en_s    = {N_DRV{1'b0}};
               state_s = IDLE;
            end
         end
         GRANT: begin
            if (cnt_r == {CW{1'b0}}) begin
               data_out_s   = bus_in;
               data_valid_s = 1'b1;
               en_s         = {N_DRV{1'b0}};
               state_s      = SAMPLE;
               if (grant_id_r == IW'(N_DRV - 1)) begin
                  ptr_s = {IW{1'b0}};
               end else begin
                  ptr_s = grant_id_r + IW'(1);
               end
            end else begin
               cnt_s = cnt_r - CW'(1);
            end
         end
         SAMPLE: begin
            en_s = {N_DRV{1'b0}};
            if (DEAD_CYC == 0) begin
               state_s = IDLE;
            end else begin
               cnt_s   = CW'(DEAD_CYC - 1);
               state_s = DEAD;
            end
         end
         DEAD: begin
            en_s = {N_DRV{1'b0}};
            if (cnt_r == {CW{1'b0}}) begin
               state_s = IDLE;
            end else begin
               cnt_s = cnt_r - CW'(1);
            end
         end
         default: begin
            en_s    = {N_DRV{1'b0}};
            state_s = IDLE;
         end
      endcase
      busy_s = (state_s != IDLE);
   end

   // Error flag update: a new error at the sample edge wins over clr_err.
   always_comb begin
`ifdef TRI_BUS_XZ_CHECK_EN
      float_set_s = (state_r == GRANT) && (cnt_r == {CW{1'b0}}) && (bus_in === 1'bz);
      cont_set_s  = (state_r == GRANT) && (cnt_r == {CW{1'b0}}) && (bus_in === 1'bx);
`else
      float_set_s = 1'b0;
      cont_set_s  = 1'b0;
`endif
      if (float_set_s) begin
         float_s = 1'b1;
      end else if (clr_err) begin
         float_s = 1'b0;
      end else begin
         float_s = float_r;
      end
      if (cont_set_s) begin
         cont_s = 1'b1;
      end else if (clr_err) begin
         cont_s = 1'b0;
      end else begin
         cont_s = cont_r;
      end
   end

   // State and output registers; async reset drops the enables at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= IDLE;
         cnt_r        <= {CW{1'b0}};
         en_r         <= {N_DRV{1'b0}};
         grant_id_r   <= {IW{1'b0}};
         ptr_r        <= {IW{1'b0}};
         data_out_r   <= 1'b0;
         data_valid_r <= 1'b0;
         busy_r       <= 1'b0;
         float_r      <= 1'b0;
         cont_r       <= 1'b0;
      end else begin
         state_r      <= state_s;
         cnt_r        <= cnt_s;
         en_r         <= en_s;
         grant_id_r   <= grant_id_s;
         ptr_r        <= ptr_s;
         data_out_r   <= data_out_s;
         data_valid_r <= data_valid_s;
         busy_r       <= busy_s;
         float_r      <= float_s;
         cont_r       <= cont_s;
      end
   end

   assign en             = en_r;
   assign grant_id       = grant_id_r;
   assign data_out       = data_out_r;
   assign data_valid     = data_valid_r;
   assign busy           = busy_r;
   assign float_err      = float_r;
   assign contention_err = cont_r;

endmodule

// File: tb/tb_tri_bus_ctrl.sv
// Directed self-checking bench for tri_bus_ctrl (N_DRV=3, SETTLE_CYC=2, DEAD_CYC=1).
// The net is modelled as the wired value of whichever driver is enabled.
module tb_tri_bus_ctrl;

   localparam int N = 3;

   logic         clk;
   logic         rst_n;
   logic [N-1:0] req;
   logic         bus_in;
   logic         clr_err;
   logic [N-1:0] en;
   logic [1:0]   grant_id;
   logic         data_out;
   logic         data_valid;
   logic         busy;
   logic         float_err;
   logic         contention_err;

   logic [N-1:0] drv_val;
   logic         bus_force_en;
   logic         bus_force_val;

   int n_checks;
   int n_errors;
   int onehot_viol;
   int gap;

   assign bus_in = bus_force_en ? bus_force_val : |(en & drv_val);

   tri_bus_ctrl #(
      .N_DRV      (3),
      .SETTLE_CYC (2),
      .DEAD_CYC   (1)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req            (req),
      .bus_in         (bus_in),
      .clr_err        (clr_err),
      .en             (en),
      .grant_id       (grant_id),
      .data_out       (data_out),
      .data_valid     (data_valid),
      .busy           (busy),
      .float_err      (float_err),
      .contention_err (contention_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count any cycle in which more than one enable is high.
   always @(negedge clk) begin
      if ((en & (en - 3'd1)) != 3'd0) onehot_viol = onehot_viol + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks = n_checks + 1;
      if (got !== exp) begin
         n_errors = n_errors + 1;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   // Wait (bounded) for the next grant, then follow it to its sample cycle.
   task automatic run_txn(input int g, output int zeros);
      logic [N-1:0] exp_en;
      exp_en = 3'b001 << g;
      zeros = 0;
      while (en == 3'b000 && zeros < 12) begin
         tick();
         if (en == 3'b000) zeros = zeros + 1;
      end
      check_eq("txn_gid", 32'(grant_id), 32'(g));
      check_eq("txn_en", 32'(en), 32'(exp_en));
      tick();
      check_eq("txn_en_hold", 32'(en), 32'(exp_en));
      check_eq("txn_dv_early", 32'(data_valid), 32'd0);
      tick();
      check_eq("txn_dv", 32'(data_valid), 32'd1);
      check_eq("txn_data", 32'(data_out), 32'(drv_val[g]));
      check_eq("txn_en_off", 32'(en), 32'd0);
   endtask

   initial begin
      n_checks      = 0;
      n_errors      = 0;
      onehot_viol   = 0;
      rst_n         = 1'b0;
      req           = 3'b000;
      clr_err       = 1'b0;
      drv_val       = 3'b010;
      bus_force_en  = 1'b0;
      bus_force_val = 1'b0;

      // Reset state
      tick();
      check_eq("rst_en", 32'(en), 32'd0);
      check_eq("rst_gid", 32'(grant_id), 32'd0);
      check_eq("rst_data", 32'(data_out), 32'd0);
      check_eq("rst_dv", 32'(data_valid), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_ferr", 32'(float_err), 32'd0);
      check_eq("rst_cerr", 32'(contention_err), 32'd0);
      rst_n = 1'b1;
      tick();

      // Single request: req=010 at cycle 0
      req = 3'b010;
      tick();                                  // cycle 1
      req = 3'b000;
      check_eq("single_en_c1", 32'(en), 32'b010);
      check_eq("single_gid", 32'(grant_id), 32'd1);
      check_eq("single_busy", 32'(busy), 32'd1);
      tick();                                  // cycle 2
      check_eq("single_en_c2", 32'(en), 32'b010);
      check_eq("single_dv_c2", 32'(data_valid), 32'd0);
      tick();                                  // cycle 3
      check_eq("single_dv_c3", 32'(data_valid), 32'd1);
      check_eq("single_data", 32'(data_out), 32'd1);
      check_eq("single_en_c3", 32'(en), 32'd0);
      tick();                                  // cycle 4
      check_eq("single_en_c4", 32'(en), 32'd0);
      check_eq("single_dv_c4", 32'(data_valid), 32'd0);
      check_eq("single_busy_c4", 32'(busy), 32'd1);
      tick();                                  // cycle 5
      check_eq("single_busy_c5", 32'(busy), 32'd0);
      check_eq("single_en_c5", 32'(en), 32'd0);
      check_eq("single_gid_keep", 32'(grant_id), 32'd1);

      // Default build: clr_err on clean flags keeps them low
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      check_eq("clr_ferr", 32'(float_err), 32'd0);

      // Round-robin with all requesting, from pointer 0: order 0,1,2,0.
      // Between grants: SAMPLE cycle, then DEAD and IDLE = 2 more zero cycles.
      do_reset();
      drv_val = 3'b101;
      req     = 3'b111;
      run_txn(0, gap);
      check_eq("rr_gap0", 32'(gap), 32'd0);
      run_txn(1, gap);
      check_eq("rr_gap1", 32'(gap), 32'd2);
      run_txn(2, gap);
      check_eq("rr_gap2", 32'(gap), 32'd2);
      run_txn(0, gap);
      check_eq("rr_gap3", 32'(gap), 32'd2);

      // Wrap: pointer is 1 here; grant 1 moves it to 2, then req=011 -> 0, 1
      req = 3'b010;
      run_txn(1, gap);
      req = 3'b011;
      run_txn(0, gap);
      check_eq("wrap_gap", 32'(gap), 32'd2);
      run_txn(1, gap);
      req = 3'b000;
      tick();
      tick();
      tick();
      check_eq("wrap_idle", 32'(busy), 32'd0);

      // Async reset in the middle of GRANT
      req = 3'b001;
      tick();                                  // cycle 1
      tick();                                  // cycle 2
      check_eq("arst_pre_en", 32'(en), 32'b001);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("arst_en", 32'(en), 32'd0);
      check_eq("arst_gid", 32'(grant_id), 32'd0);
      check_eq("arst_busy", 32'(busy), 32'd0);
      check_eq("arst_dv", 32'(data_valid), 32'd0);
      req = 3'b000;
      tick();
      check_eq("arst_dv_hold", 32'(data_valid), 32'd0);
      rst_n = 1'b1;
      tick();
      check_eq("arst_en_after", 32'(en), 32'd0);

      // Request withdrawn during GRANT still completes
      drv_val = 3'b001;
      req     = 3'b001;
      tick();                                  // cycle 1
      req = 3'b000;
      check_eq("wd_en_c1", 32'(en), 32'b001);
      tick();                                  // cycle 2
      check_eq("wd_en_c2", 32'(en), 32'b001);
      tick();                                  // cycle 3
      check_eq("wd_dv", 32'(data_valid), 32'd1);
      check_eq("wd_data", 32'(data_out), 32'd1);
      tick();                                  // cycle 4
      check_eq("wd_dv_pulse", 32'(data_valid), 32'd0);
      tick();                                  // cycle 5
      tick();                                  // cycle 6
      check_eq("wd_no_regrant", 32'(en), 32'd0);

`ifdef TRI_BUS_XZ_CHECK_EN
      // Floating net, then contended net, then clear
      bus_force_en  = 1'b1;
      bus_force_val = 1'bz;
      req = 3'b001;
      tick();
      req = 3'b000;
      tick();
      tick();
      check_eq("xz_float", 32'(float_err), 32'd1);
      tick();
      tick();
      bus_force_val = 1'bx;
      req = 3'b001;
      tick();
      req = 3'b000;
      tick();
      tick();
      check_eq("xz_cont", 32'(contention_err), 32'd1);
      bus_force_en = 1'b0;
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      check_eq("xz_clr_f", 32'(float_err), 32'd0);
      check_eq("xz_clr_c", 32'(contention_err), 32'd0);
`endif

      check_eq("onehot0", 32'(onehot_viol), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/tri_bus_ctrl.md
Name: tri_bus_ctrl

Overview:
Controller and receiver for a shared single-bit tri-state net. The net is driven by N enable-controlled CMOS gate drivers (controlled inverter/NAND style, with active-high enable). The block grants the bus round-robin by raising exactly one driver enable. It waits a settle interval that covers transistor rise/fall/turn-off delays, then samples the net. It inserts a break-before-make dead interval before the next grant.

Parameters:
- N_DRV, 3, number of tri-state drivers on the net (2..8).
- SETTLE_CYC, 2, cycles en is held before sampling (>=1).
- DEAD_CYC, 1, cycles with all enables low after a sample (>=0).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N_DRV  per-driver bus request, level.
- bus_in  input  1  shared tri-state net being sampled.
- clr_err  input  1  synchronous clear of sticky error flags.
- en  output  N_DRV  one-hot active-high driver enables (EN of each gate).
- grant_id  output  $clog2(N_DRV)  index of the current or last granted driver.
- data_out  output  1  last sampled bus value.
- data_valid  output  1  one-cycle pulse when data_out is updated.
- busy  output  1  high in any state other than IDLE.
- float_err  output  1  sticky flag: sampled value was Z.
- contention_err  output  1  sticky flag: sampled value was X.

Behaviour:
- Reset (async, rst_n=0): en=0 immediately (no clock needed, bus-safety requirement). grant_id=0, data_out=0, data_valid=0, busy=0, errors=0, rr pointer=0, state IDLE.
- States: IDLE, GRANT, SAMPLE, DEAD.
- IDLE:
  - If |req, select the first requester at or above the rr pointer, wrapping modulo N_DRV.
  - Next edge: en[sel]=1, grant_id=sel, cnt=SETTLE_CYC-1, state GRANT.
  - If no request, stay in IDLE with en=0.
- GRANT:
  - en held one-hot for exactly SETTLE_CYC cycles.
  - When cnt==0, next edge: data_out<=bus_in, data_valid=1, en<=0, rr pointer<=sel+1 (wraps N_DRV-1 -> 0).
  - Then go to DEAD with cnt=DEAD_CYC-1, or to IDLE if DEAD_CYC==0.
- SAMPLE: the single-cycle state in which data_valid is high and en is 0.
- DEAD: en=0 for DEAD_CYC cycles, then IDLE.
- Latency: req seen in IDLE at cycle t -> en high from t+1 -> data_valid at t+1+SETTLE_CYC.
- Back-to-back grants are separated by at least DEAD_CYC+1 cycles with en=0 (includes the SAMPLE cycle).
- req is sampled only in IDLE. Withdrawing req during GRANT does not abort the transaction. A new req during GRANT/DEAD waits.
- Invariant: $onehot0(en) every cycle. Two enables high at once is a design bug.
- clr_err clears both error flags on the next edge. A simultaneous error set takes priority over clr_err.
- Reset mid-GRANT drops en immediately and discards the sample; no data_valid is issued.

Optional Feature:
Macro TRI_BUS_XZ_CHECK_EN.
- Defined: in SAMPLE, bus_in===1'bz sets float_err and bus_in===1'bx sets contention_err. data_out still captures the raw value.
- Undefined: float_err and contention_err are tied to 0. No 4-state comparisons are compiled, keeping the block synthesizable.

Decomposition:
- Package tri_bus_pkg holds:
  - state enum type (IDLE, GRANT, SAMPLE, DEAD);
  - the cnt width derived from max(SETTLE_CYC, DEAD_CYC);
  - the grant_id width function.
- One natural sub-module: tri_bus_rr_arb. It is combinational priority select given req and pointer, outputs a one-hot grant and an index.

Test Plan (N_DRV=3, SETTLE_CYC=2, DEAD_CYC=1):
- Single request: req=3'b010 at cycle 0 -> en=010 during cycles 1-2, data_valid at cycle 3 with data_out equal to the driver's output, en=000 during cycles 3-4, next grant no earlier than cycle 5.
- Round-robin fairness: req=3'b111 held -> grant order 0,1,2,0. No two en bits high in any cycle. At least 2 zero-en cycles between grants.
- Wrap: pointer=2, req=3'b011 -> grant 0, then 1.
- Async reset mid-GRANT: drop rst_n at cycle 2 between edges -> en=000 within the same timestep, no data_valid, grant_id=0, busy=0.
- XZ check (macro on): enable a driver but leave the net undriven -> float_err=1. Drive 0 and 1 together -> contention_err=1. clr_err pulse -> both flags 0 next edge.
- Req withdrawn during GRANT: req 001 -> 000 at cycle 1 -> the transaction still completes and data_valid fires at cycle 3.
